freq_display: RTL
=================

FREQ_DISPLAY -- requirements
Module: freq_display

Interface
REQ-001 Parameter CNT_SCAN_MAX, default 99_999, sys_clk cycles per scan slot minus one (1 ms at 100 MHz).
REQ-002 sys_clk  input  1  system clock, 100 MHz.
REQ-003 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 freq  input  34  measured frequency in Hz, registered in the sys_clk domain.
REQ-005 an  output  8  digit enables, active-high; an[k] = digit k, k=0 rightmost.
REQ-006 seg0  output  8  segments for digits 0..3; [7]=dp, [6:0]=g..a, active-high.
REQ-007 seg1  output  8  segments for digits 4..7, same encoding.
REQ-008 conv_busy  output  1  high while a BCD conversion is in progress.

Function
REQ-009 The block SHALL use a conversion FSM with states IDLE and CONV.
REQ-010 In IDLE, when freq != freq_last, the block SHALL latch freq into the shift register and freq_last, clear the 44-bit BCD accumulator, and enter CONV on that edge.
REQ-011 Each CONV cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one bit.
REQ-012 After exactly 34 CONV cycles, the block SHALL copy the 11-digit result into bcd_disp and return to IDLE. bcd_disp therefore updates 34 cycles after the sampling edge.
REQ-013 conv_busy SHALL equal (state == CONV).
REQ-014 A freq change during CONV SHALL NOT affect the running conversion; it SHALL be sampled in the first IDLE cycle afterwards.
REQ-015 bcd_disp SHALL hold the previous result until a conversion completes (double buffered).
REQ-016 Hz mode: if bcd_disp digits 10..8 are all zero, display digits 7..0 and keep all dp off.
REQ-017 kHz mode: otherwise display digits 10..3 and light the dp of digit 0 only.
REQ-018 Leading-zero blanking: every displayed digit above the most significant nonzero digit SHALL output 0x00. Digit 0 is never blanked.
REQ-019 Segment codes SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, and blank:00.
REQ-020 Scan counter: a counter SHALL count 0..CNT_SCAN_MAX and wrap. Scan index i (0..3) SHALL advance on each wrap, and i=3 SHALL wrap to 0.
REQ-021 The block SHALL drive an = (1<<i)|(1<<(i+4)), seg0 = code of digit i, and seg1 = code of digit i+4.
REQ-022 an, seg0 and seg1 SHALL be registered, updating one cycle after the index or bcd_disp changes.

Reset
REQ-023 On reset the block SHALL set state=IDLE, freq_last=0, bcd_disp=0, scan counter=0, i=0, an=0, seg0=0, seg1=0 and conv_busy=0.
REQ-024 After reset release with freq=0, the display SHALL show "0" on digit 0 only, with no conversion started.
REQ-025 Reset asserted mid-conversion SHALL abort it and discard the partial result.

Structure
REQ-026 A shared package SHALL hold the segment code constants, the BCD digit count (11), the binary width (34) and the FSM state encoding.
REQ-027 One sub-module, bin2bcd_seq, SHALL contain the conversion FSM. freq_display SHALL instantiate it and contain the mode, blanking and scan logic.

Verification
REQ-028 Set CNT_SCAN_MAX=3 with bcd_disp fixed. Required: an cycles 0x11, 0x22, 0x44, 0x88, each for 4 cycles, and repeats.
REQ-029 freq=12_345_678. Required: conv_busy high for 34 cycles; then digits 7..0 show 06,5B,4F,66,6D,7D,07,7F; all dp off.
REQ-030 freq=100_000_000. Required: kHz mode; digits 5..0 show 06,3F,3F,3F,3F,3F; digits 7..6 blank; seg0[7]=1 only while i=0.
REQ-031 freq=17_179_869_183. Required: digits 7..0 show 1,7,1,7,9,8,6,9 with the digit-0 dp lit.
REQ-032 freq 5 -> 7 at CONV cycle 10. Required: display shows 5, then a second conversion runs and the display shows 7.
REQ-033 Reset pulsed at CONV cycle 20. Required: all outputs 0 during reset, then digit 0 shows 3F and conv_busy restarts only if freq != 0.

Source files
------------

// File: rtl/freq_display_pkg.sv
// -----------------------------------------------------------------------------
// freq_display_pkg
// Shared definitions for the frequency display slice: binary/BCD widths,
// conversion FSM state encoding and seven-segment glyph codes.
// No ports (package).
// -----------------------------------------------------------------------------
package freq_display_pkg;

  // Binary input width and number of BCD digits needed to hold 2^34-1.
  localparam int BIN_W       = 34;
  localparam int BCD_DIGITS  = 11;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int CONV_CYCLES = BIN_W;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  // Segment codes, bit order g..a, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Map one BCD digit to its glyph; non-decimal codes render blank.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/freq_display_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter. Whenever the input differs from the
// last converted value it runs one 34-cycle conversion and then publishes the
// 11-digit result to a holding register, which keeps the old value meanwhile.
// Ports:
//   sys_clk   - clock
//   sys_rst_n - asynchronous active-low reset
//   bin_i     - binary value to convert
//   bcd_o     - last completed BCD result (digit 10 in the top nibble)
//   busy_o    - high while a conversion is running
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import freq_display_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             busy_o
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] freq_last_q, freq_last_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] adj;
  logic [5:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_disp_q, bcd_disp_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      freq_last_q <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_disp_q  <= '0;
    end else begin
      state_q     <= state_d;
      freq_last_q <= freq_last_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_disp_q  <= bcd_disp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    freq_last_d = freq_last_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_disp_d  = bcd_disp_q;

    // Add-3 correction so that the following left shift carries correctly
    // from one decimal digit into the next.
    adj = acc_q;
    for (int n = 0; n < BCD_DIGITS; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (bin_i != freq_last_q) begin
          state_d     = CONV;
          bin_d       = bin_i;
          freq_last_d = bin_i;
          acc_d       = '0;
          cnt_d       = '0;
        end
      end
      CONV: begin
        {acc_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 6'd1;
        if (cnt_q == 6'(CONV_CYCLES - 1)) begin
          state_d    = IDLE;
          bcd_disp_d = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_o  = bcd_disp_q;
  assign busy_o = (state_q == CONV);

endmodule

// File: rtl/freq_display.sv
// -----------------------------------------------------------------------------
// freq_display
// Shows a measured frequency on eight multiplexed seven-segment digits. Values
// below 100 MHz are shown in Hz; larger values are shown in kHz with the
// decimal point of digit 0 lit. Leading zeros are blanked.
// Ports:
//   sys_clk   - 100 MHz clock
//   sys_rst_n - asynchronous active-low reset
//   freq      - measured frequency in Hz
//   an        - digit enables, two digits (i and i+4) active at a time
//   seg0      - segments {dp, g..a} for digits 0..3
//   seg1      - segments {dp, g..a} for digits 4..7
//   conv_busy - BCD conversion in progress
// -----------------------------------------------------------------------------
module freq_display
  import freq_display_pkg::*;
#(
  parameter int CNT_SCAN_MAX = 99_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] freq,
  output logic [7:0]       an,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1,
  output logic             conv_busy
);

  localparam int SCAN_W = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;

  logic [BCD_W-1:0]  bcd_disp;
  logic              hz_mode;
  logic              lead_zero;
  logic [3:0]        dig  [8];
  logic [6:0]        code [8];
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg0_q, seg0_d;
  logic [7:0]        seg1_q, seg1_d;

  bin2bcd_seq u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin_i     (freq),
    .bcd_o     (bcd_disp),
    .busy_o    (conv_busy)
  );

  // Pick the eight visible digits and blank everything above the most
  // significant nonzero one, walking from the top digit downwards.
  always_comb begin
    hz_mode   = (bcd_disp[BCD_W-1:32] == '0);
    lead_zero = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      dig[k]    = hz_mode ? bcd_disp[4*k +: 4] : bcd_disp[4*(k+3) +: 4];
      lead_zero = lead_zero && (dig[k] == 4'd0);
      code[k]   = (lead_zero && (k != 0)) ? SEG_BLANK : seg_code(dig[k]);
    end
  end

  // Scan timing and the next values of the registered display outputs.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(CNT_SCAN_MAX)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
    an_d   = 8'h11 << idx_q;
    seg0_d = {(!hz_mode && (idx_q == 2'd0)), code[{1'b0, idx_q}]};
    seg1_d = {1'b0, code[{1'b1, idx_q}]};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '0;
      seg0_q     <= '0;
      seg1_q     <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg0_q     <= seg0_d;
      seg1_q     <= seg1_d;
    end
  end

  assign an   = an_q;
  assign seg0 = seg0_q;
  assign seg1 = seg1_q;

endmodule
